// File: rtl/mon_accum.sv
// Multi-channel accumulate-and-dump: sums NCH time-multiplexed signed channels
// over a latched number of frames and emits one strobed sum per channel on the dump frame.
module mon_accum #(
   parameter int unsigned IW  = 18,
   parameter int unsigned DW  = 32,
   parameter int unsigned NCH = 12,
   parameter int unsigned PW  = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [IW-1:0] data_in,
   input  logic          strobe_in,
   input  logic          sync_in,
   input  logic [PW-1:0] period,
   input  logic          err_clr,
   output logic [DW-1:0] data_out,
   output logic          strobe_out,
   output logic [3:0]    chan_out,
   output logic          frame_err
);

   localparam int unsigned CW = 4;

   typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

   state_t        state, state_d;
   logic [CW-1:0] ch, ch_d;
   logic [PW-1:0] fcnt, fcnt_d;
   logic [PW-1:0] plat, plat_d;
   logic          wrap_pend, wrap_pend_d;
   logic          dump_end, dump_end_d;
   logic [DW-1:0] acc [NCH];

   logic          acc_we;
   logic [CW-1:0] acc_idx;
   logic [DW-1:0] acc_wdata;
   logic [DW-1:0] data_out_d;
   logic          strobe_out_d;
   logic [3:0]    chan_out_d;
   logic          frame_err_d;

   logic [PW-1:0] maxp;
   logic [PW-1:0] plat_eff;
   logic [PW-1:0] fidx;
   logic [CW-1:0] chan;
   logic          take;
   logic          set_err;
   logic          short_dump;
   logic [DW-1:0] sum;

   // Next-state, accumulator write and output decode for one accepted strobe
   always_comb begin
      state_d      = state;
      ch_d         = ch;
      fcnt_d       = fcnt;
      wrap_pend_d  = wrap_pend;
      dump_end_d   = 1'b0;
      acc_we       = 1'b0;
      acc_idx      = '0;
      acc_wdata    = '0;
      data_out_d   = data_out;
      strobe_out_d = 1'b0;
      chan_out_d   = chan_out;
      frame_err_d  = err_clr ? 1'b0 : frame_err;
      maxp         = (period == '0) ? PW'(1) : period;
      plat_eff     = plat;
      fidx         = fcnt;
      chan         = ch;
      take         = 1'b0;
      set_err      = 1'b0;
      short_dump   = 1'b0;
      sum          = '0;

      case (state)
         HUNT: begin
            if (strobe_in && sync_in) begin
               state_d  = RUN;
               take     = 1'b1;
               chan     = '0;
               fidx     = '0;
               plat_eff = maxp;
            end
         end
         RUN: begin
            // new interval starts the cycle after the last dump word
            if (dump_end) plat_eff = maxp;
            if (strobe_in) begin
               if (sync_in) begin
                  short_dump  = !wrap_pend && (fcnt == plat - PW'(1));
                  set_err     = (ch != CW'(NCH - 1));
                  if (short_dump) plat_eff = maxp;
                  fidx        = (wrap_pend || short_dump) ? '0 : fcnt + PW'(1);
                  wrap_pend_d = 1'b0;
                  chan        = '0;
                  take        = 1'b1;
               end else if (ch == CW'(NCH - 1)) begin
                  set_err = 1'b1;
               end else begin
                  chan = ch + CW'(1);
                  take = 1'b1;
               end
            end
         end
         default: state_d = HUNT;
      endcase

      plat_d = plat_eff;

      if (take) begin
         ch_d    = chan;
         fcnt_d  = fidx;
         sum     = acc[chan] + DW'($signed(data_in));
         acc_we  = 1'b1;
         acc_idx = chan;
         if (fidx == plat_eff - PW'(1)) begin
            acc_wdata    = '0;
            data_out_d   = sum;
            chan_out_d   = 4'(chan);
            strobe_out_d = 1'b1;
            if (chan == CW'(NCH - 1)) begin
               wrap_pend_d = 1'b1;
               dump_end_d  = 1'b1;
            end
         end else begin
            acc_wdata = sum;
         end
      end

      if (set_err) frame_err_d = 1'b1;
   end

   // State, counters, accumulators and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= HUNT;
         ch         <= '0;
         fcnt       <= '0;
         plat       <= '0;
         wrap_pend  <= 1'b0;
         dump_end   <= 1'b0;
         data_out   <= '0;
         strobe_out <= 1'b0;
         chan_out   <= '0;
         frame_err  <= 1'b0;
         for (int i = 0; i < NCH; i++) acc[i] <= '0;
      end else begin
         state      <= state_d;
         ch         <= ch_d;
         fcnt       <= fcnt_d;
         plat       <= plat_d;
         wrap_pend  <= wrap_pend_d;
         dump_end   <= dump_end_d;
         data_out   <= data_out_d;
         strobe_out <= strobe_out_d;
         chan_out   <= chan_out_d;
         frame_err  <= frame_err_d;
         if (acc_we) acc[acc_idx] <= acc_wdata;
      end
   end

endmodule

// File: tb/tb_mon_accum.sv
// Directed bench for mon_accum: reset/hunt, dump periods, period change,
// frame errors and async reset in the middle of a dump burst.
module tb_mon_accum;

   localparam int unsigned IW  = 18;
   localparam int unsigned DW  = 32;
   localparam int unsigned NCH = 12;
   localparam int unsigned PW  = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [IW-1:0] data_in = '0;
   logic          strobe_in = 1'b0;
   logic          sync_in = 1'b0;
   logic [PW-1:0] period = PW'(1);
   logic          err_clr = 1'b0;
   logic [DW-1:0] data_out;
   logic          strobe_out;
   logic [3:0]    chan_out;
   logic          frame_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mon_accum #(.IW(IW), .DW(DW), .NCH(NCH), .PW(PW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .strobe_in  (strobe_in),
      .sync_in    (sync_in),
      .period     (period),
      .err_clr    (err_clr),
      .data_out   (data_out),
      .strobe_out (strobe_out),
      .chan_out   (chan_out),
      .frame_err  (frame_err)
   );

   task automatic reset_dut(input int p);
      strobe_in = 1'b0;
      sync_in   = 1'b0;
      data_in   = '0;
      err_clr   = 1'b0;
      period    = PW'(p);
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One strobe; returns 1 time unit after the sampling edge
   task automatic send(input logic s, input int d);
      data_in   = IW'(d);
      sync_in   = s;
      strobe_in = 1'b1;
      @(posedge clk);
      #1;
      strobe_in = 1'b0;
      sync_in   = 1'b0;
      data_in   = '0;
   endtask

   task automatic clr_pulse();
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (data_out !== '0 || strobe_out !== 1'b0 || chan_out !== 4'd0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: data=%h strobe=%b chan=%0d err=%b want all 0", data_out, strobe_out, chan_out, frame_err);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      period = PW'(1);
      for (int k = 0; k < 5; k++) begin
         send(1'b0, 1000 + k);
         total++;
         if (strobe_out !== 1'b0) begin
            bad++;
            $display("FAIL hunt_nostrobe k=%0d: got %b want 0", k, strobe_out);
         end
      end
      total++;
      if (data_out !== '0 || chan_out !== 4'd0 || frame_err !== 1'b0) begin
         bad++;
         $display("FAIL hunt_outputs: data=%h chan=%0d err=%b want 0", data_out, chan_out, frame_err);
      end
   endtask

   task automatic test_period1();
      for (int pass = 0; pass < 2; pass++) begin
         reset_dut(pass == 0 ? 1 : 0);
         for (int k = 0; k < NCH; k++) begin
            send(k == 0, k - 6);
            total++;
            if (strobe_out !== 1'b1 || chan_out !== 4'(k) || data_out !== DW'(k - 6)) begin
               bad++;
               $display("FAIL p1_word pass=%0d k=%0d: strobe=%b chan=%0d data=%h want 1 %0d %h",
                        pass, k, strobe_out, chan_out, data_out, k, DW'(k - 6));
            end
         end
         @(posedge clk);
         #1;
         total++;
         if (strobe_out !== 1'b0 || chan_out !== 4'd11 || data_out !== DW'(5)) begin
            bad++;
            $display("FAIL p1_hold pass=%0d: strobe=%b chan=%0d data=%h want 0 11 5", pass, strobe_out, chan_out, data_out);
         end
      end
   endtask

   task automatic test_period4();
      reset_dut(4);
      for (int f = 0; f < 8; f++) begin
         for (int k = 0; k < NCH; k++) begin
            send(k == 0, f < 4 ? -131072 : k);
            if (f % 4 != 3) begin
               total++;
               if (strobe_out !== 1'b0) begin
                  bad++;
                  $display("FAIL p4_quiet f=%0d k=%0d: strobe got %b want 0", f, k, strobe_out);
               end
            end else begin
               total++;
               if (strobe_out !== 1'b1 || chan_out !== 4'(k) ||
                   data_out !== DW'(f == 3 ? -524288 : 4 * k)) begin
                  bad++;
                  $display("FAIL p4_dump f=%0d k=%0d: strobe=%b chan=%0d data=%h want 1 %0d %h",
                           f, k, strobe_out, chan_out, data_out, k, DW'(f == 3 ? -524288 : 4 * k));
               end
            end
         end
      end
   endtask

   task automatic test_period_change();
      reset_dut(3);
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k < NCH; k++) begin
            if (f == 1 && k == 6) period = PW'(2);
            send(k == 0, f < 3 ? 1 : 10);
            if (f == 2 || f == 4) begin
               total++;
               if (strobe_out !== 1'b1 || chan_out !== 4'(k) || data_out !== DW'(f == 2 ? 3 : 20)) begin
                  bad++;
                  $display("FAIL pchg_dump f=%0d k=%0d: strobe=%b chan=%0d data=%h want 1 %0d %0d",
                           f, k, strobe_out, chan_out, data_out, k, f == 2 ? 3 : 20);
               end
            end else if (k == 0 || k == NCH - 1) begin
               total++;
               if (strobe_out !== 1'b0) begin
                  bad++;
                  $display("FAIL pchg_quiet f=%0d k=%0d: strobe got %b want 0", f, k, strobe_out);
               end
            end
         end
      end
   endtask

   task automatic test_frame_err();
      reset_dut(2);
      for (int k = 0; k < NCH - 1; k++) send(k == 0, 100);
      total++;
      if (frame_err !== 1'b0 || strobe_out !== 1'b0) begin
         bad++;
         $display("FAIL ferr_pre: err=%b strobe=%b want 0 0", frame_err, strobe_out);
      end
      send(1'b1, 100);
      total++;
      if (frame_err !== 1'b1 || strobe_out !== 1'b1 || chan_out !== 4'd0 || data_out !== DW'(200)) begin
         bad++;
         $display("FAIL ferr_short: err=%b strobe=%b chan=%0d data=%0d want 1 1 0 200", frame_err, strobe_out, chan_out, data_out);
      end
      clr_pulse();
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL ferr_clr1: got %b want 0", frame_err);
      end
      for (int k = 1; k < NCH; k++) begin
         send(1'b0, 100);
         total++;
         if (strobe_out !== 1'b1 || chan_out !== 4'(k) || data_out !== DW'(k == NCH - 1 ? 100 : 200)) begin
            bad++;
            $display("FAIL ferr_dump k=%0d: strobe=%b chan=%0d data=%0d want 1 %0d %0d",
                     k, strobe_out, chan_out, data_out, k, k == NCH - 1 ? 100 : 200);
         end
      end
      send(1'b0, 5000);
      total++;
      if (frame_err !== 1'b1 || strobe_out !== 1'b0 || chan_out !== 4'd11 || data_out !== DW'(100)) begin
         bad++;
         $display("FAIL ferr_long: err=%b strobe=%b chan=%0d data=%0d want 1 0 11 100", frame_err, strobe_out, chan_out, data_out);
      end
      clr_pulse();
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL ferr_clr2: got %b want 0", frame_err);
      end
      err_clr = 1'b1;
      send(1'b0, 5000);
      err_clr = 1'b0;
      total++;
      if (frame_err !== 1'b1 || strobe_out !== 1'b0) begin
         bad++;
         $display("FAIL ferr_setwins: err=%b strobe=%b want 1 0", frame_err, strobe_out);
      end
      clr_pulse();
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < NCH; k++) begin
            send(k == 0, 7);
            if (f == 1) begin
               total++;
               if (strobe_out !== 1'b1 || chan_out !== 4'(k) || data_out !== DW'(14)) begin
                  bad++;
                  $display("FAIL ferr_after k=%0d: strobe=%b chan=%0d data=%0d want 1 %0d 14", k, strobe_out, chan_out, data_out, k);
               end
            end
         end
      end
      total++;
      if (frame_err !== 1'b0) begin
         bad++;
         $display("FAIL ferr_final: got %b want 0", frame_err);
      end
   endtask

   task automatic test_reset_midburst();
      reset_dut(2);
      for (int k = 0; k < NCH; k++) send(k == 0, 50);
      for (int k = 0; k < 6; k++) send(k == 0, 50);
      total++;
      if (strobe_out !== 1'b1 || chan_out !== 4'd5 || data_out !== DW'(100)) begin
         bad++;
         $display("FAIL rst_pre: strobe=%b chan=%0d data=%0d want 1 5 100", strobe_out, chan_out, data_out);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (strobe_out !== 1'b0 || data_out !== '0 || chan_out !== 4'd0) begin
         bad++;
         $display("FAIL rst_drop: strobe=%b chan=%0d data=%0d want 0 0 0", strobe_out, chan_out, data_out);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 6; k < NCH; k++) begin
         send(1'b0, 999);
         total++;
         if (strobe_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_hunt k=%0d: strobe got %b want 0", k, strobe_out);
         end
      end
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < NCH; k++) begin
            send(k == 0, 3);
            total++;
            if (f == 0 && strobe_out !== 1'b0) begin
               bad++;
               $display("FAIL rst_quiet k=%0d: strobe got %b want 0", k, strobe_out);
            end else if (f == 1 && (strobe_out !== 1'b1 || chan_out !== 4'(k) || data_out !== DW'(6))) begin
               bad++;
               $display("FAIL rst_post k=%0d: strobe=%b chan=%0d data=%0d want 1 %0d 6", k, strobe_out, chan_out, data_out, k);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_period1();
      test_period4();
      test_period_change();
      test_frame_err();
      test_reset_midburst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
